// File: rtl/wifi_tx_mapper_ctrl_if.sv
// rtl/wifi_tx_mapper_ctrl_if.sv - bit-stream, start/config and mapper-strobe signals of the TX mapper sequencer
// Optional pilot_slot member exists only when WIFI_TX_MAPPER_CTRL_PILOT_EN is defined.
interface wifi_tx_mapper_ctrl_if;
    logic       frame_start;
    logic [1:0] mod_sel;
    logic [7:0] n_sym;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       out_ready;
    logic       map_valid;
    logic [1:0] map_sel;
    logic [5:0] map_data;
    logic [5:0] carr_idx;
    logic       sym_done;
    logic       frame_done;
    logic       busy;
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
    logic       pilot_slot;
`endif

    modport master (
        output frame_start, mod_sel, n_sym, bit_in, bit_valid, out_ready,
        input  bit_ready, map_valid, map_sel, map_data, carr_idx, sym_done, frame_done, busy
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
        , input pilot_slot
`endif
    );

    modport slave (
        input  frame_start, mod_sel, n_sym, bit_in, bit_valid, out_ready,
        output bit_ready, map_valid, map_sel, map_data, carr_idx, sym_done, frame_done, busy
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
        , output pilot_slot
`endif
    );
endinterface

// File: rtl/wifi_tx_mapper_ctrl.sv
// rtl/wifi_tx_mapper_ctrl.sv - packs serial bits into N_BPSC groups and strobes the selected constellation mapper
// Optional pilot-slot insertion (52-slot symbols) is enabled by defining WIFI_TX_MAPPER_CTRL_PILOT_EN.
module wifi_tx_mapper_ctrl #(
    parameter int N_CARR = 48
) (
    input logic                  clk,
    input logic                  reset,
    wifi_tx_mapper_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;

`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
    localparam int N_SLOT = N_CARR + 4;
`else
    localparam int N_SLOT = N_CARR;
`endif
    localparam logic [5:0] LAST_SLOT = 6'(N_SLOT - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] mod_q, mod_d;
    logic [7:0] nsym_q, nsym_d;
    logic [7:0] sym_q, sym_d;
    logic [5:0] shreg_q, shreg_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [5:0] slot_q, slot_d;
    logic [5:0] carr_q, carr_d;
    logic       busy_q, busy_d;
    logic       map_valid_q, map_valid_d;
    logic [5:0] map_data_q, map_data_d;
    logic [5:0] carr_idx_q, carr_idx_d;
    logic       sym_done_q, sym_done_d;
    logic       frame_done_q, frame_done_d;
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
    logic       pilot_q, pilot_d;
`endif

    logic [2:0] nbpsc;
    logic       start_ok;
    logic       take_bit;
    logic       group_full;
    logic       fire;
    logic       pilot_now;
    logic       next_pilot;
    logic       data_fire;
    logic       last_slot;
    logic       last_sym;
    logic       frame_end;

    always_comb begin
        case (mod_q)
            2'b00:   nbpsc = 3'd1;
            2'b01:   nbpsc = 3'd2;
            2'b10:   nbpsc = 3'd4;
            default: nbpsc = 3'd6;
        endcase
    end

`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
    // Slot counter includes pilots; carr_q counts data carriers only.
    assign pilot_now  = (slot_q == 6'd5)  || (slot_q == 6'd19) ||
                        (slot_q == 6'd32) || (slot_q == 6'd46);
    assign next_pilot = (slot_q == 6'd4)  || (slot_q == 6'd18) ||
                        (slot_q == 6'd31) || (slot_q == 6'd45);
`else
    assign pilot_now  = 1'b0;
    assign next_pilot = 1'b0;
`endif

    assign start_ok   = (state_q == S_IDLE) && bus.frame_start && (bus.n_sym != 8'd0);
    assign take_bit   = (state_q == S_COLLECT) && bus.bit_valid;
    assign group_full = take_bit && (bcnt_q == nbpsc - 3'd1);
    assign fire       = (state_q == S_ISSUE) && bus.out_ready;
    assign data_fire  = fire && !pilot_now;
    assign last_slot  = (slot_q == LAST_SLOT);
    assign last_sym   = (sym_q == nsym_q - 8'd1);
    assign frame_end  = data_fire && last_slot && last_sym;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (group_full) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (fire) begin
                    if (frame_end)                     state_d = S_IDLE;
                    else if (next_pilot && !last_slot) state_d = S_ISSUE;
                    else                               state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.bit_ready = (state_q == S_COLLECT);
    end

    always_comb begin
        mod_d        = mod_q;
        nsym_d       = nsym_q;
        sym_d        = sym_q;
        shreg_d      = shreg_q;
        bcnt_d       = bcnt_q;
        slot_d       = slot_q;
        carr_d       = carr_q;
        busy_d       = busy_q;
        // Strobe-qualified outputs are forced to 0 whenever no carrier issues.
        map_valid_d  = data_fire;
        map_data_d   = data_fire ? shreg_q : 6'd0;
        carr_idx_d   = data_fire ? carr_q  : 6'd0;
        sym_done_d   = data_fire && last_slot;
        frame_done_d = frame_end;
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
        pilot_d      = fire && pilot_now;
`endif

        if (start_ok) begin
            mod_d   = bus.mod_sel;
            nsym_d  = bus.n_sym;
            sym_d   = 8'd0;
            shreg_d = 6'd0;
            bcnt_d  = 3'd0;
            slot_d  = 6'd0;
            carr_d  = 6'd0;
            busy_d  = 1'b1;
        end

        if (take_bit) begin
            shreg_d = {shreg_q[4:0], bus.bit_in};
            bcnt_d  = group_full ? 3'd0 : bcnt_q + 3'd1;
        end

        if (fire) begin
            if (data_fire) shreg_d = 6'd0;
            if (last_slot) begin
                slot_d = 6'd0;
                carr_d = 6'd0;
                sym_d  = sym_q + 8'd1;
            end else begin
                slot_d = slot_q + 6'd1;
                if (data_fire) carr_d = carr_q + 6'd1;
            end
        end

        if (frame_end) busy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mod_q        <= 2'd0;
            nsym_q       <= 8'd0;
            sym_q        <= 8'd0;
            shreg_q      <= 6'd0;
            bcnt_q       <= 3'd0;
            slot_q       <= 6'd0;
            carr_q       <= 6'd0;
            busy_q       <= 1'b0;
            map_valid_q  <= 1'b0;
            map_data_q   <= 6'd0;
            carr_idx_q   <= 6'd0;
            sym_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
            pilot_q      <= 1'b0;
`endif
        end else begin
            mod_q        <= mod_d;
            nsym_q       <= nsym_d;
            sym_q        <= sym_d;
            shreg_q      <= shreg_d;
            bcnt_q       <= bcnt_d;
            slot_q       <= slot_d;
            carr_q       <= carr_d;
            busy_q       <= busy_d;
            map_valid_q  <= map_valid_d;
            map_data_q   <= map_data_d;
            carr_idx_q   <= carr_idx_d;
            sym_done_q   <= sym_done_d;
            frame_done_q <= frame_done_d;
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
            pilot_q      <= pilot_d;
`endif
        end
    end

    assign bus.map_valid  = map_valid_q;
    assign bus.map_sel    = mod_q;
    assign bus.map_data   = map_data_q;
    assign bus.carr_idx   = carr_idx_q;
    assign bus.sym_done   = sym_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
    assign bus.pilot_slot = pilot_q;
`endif
endmodule

// File: tb/tb_wifi_tx_mapper_ctrl.sv
// tb/tb_wifi_tx_mapper_ctrl.sv - scoreboard bench for wifi_tx_mapper_ctrl (pilot checks when WIFI_TX_MAPPER_CTRL_PILOT_EN is defined)
module tb_wifi_tx_mapper_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wifi_tx_mapper_ctrl_if bus ();

    wifi_tx_mapper_ctrl #(.N_CARR(48)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected strobe contents: {map_data, carr_idx, sym_done, frame_done}
    logic [13:0] sb [$];
    logic [13:0] exp_e;
    int          pulses     = 0;
    logic        prev_valid = 1'b0;
    int          sym_data   = 0;
    int          pilot_k    = 0;
    int          pilots     = 0;
    int          ppos [4]   = '{5, 18, 30, 43};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nb_of(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 6;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.map_valid) begin
            pulses++;
            check("no_back_to_back", {31'd0, prev_valid}, 0);
            if (bus.frame_done) check("busy_at_frame_done", {31'd0, bus.busy}, 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_e = sb.pop_front();
                check("map_data",   {26'd0, bus.map_data}, {26'd0, exp_e[13:8]});
                check("carr_idx",   {26'd0, bus.carr_idx}, {26'd0, exp_e[7:2]});
                check("sym_done",   {31'd0, bus.sym_done}, {31'd0, exp_e[1]});
                check("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_e[0]});
            end
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
            if (bus.sym_done) begin
                check("pilots_per_sym", pilot_k, 4);
                sym_data = 0;
                pilot_k  = 0;
            end else begin
                sym_data++;
            end
`endif
        end else begin
            check("quiet_outputs", {18'd0, bus.map_data, bus.carr_idx, bus.sym_done, bus.frame_done}, 0);
        end
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
        if (bus.pilot_slot) begin
            check("pilot_excl", {31'd0, bus.map_valid}, 0);
            if (pilot_k < 4) check("pilot_pos", sym_data, ppos[pilot_k]);
            else             check("pilot_extra", pilot_k, 3);
            pilot_k++;
            pilots++;
        end
`endif
        prev_valid = bus.map_valid;
    end

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(negedge clk);
        while (!bus.bit_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.bit_ready) check("bit_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic send_carrier(input logic [1:0] m, input logic [5:0] c, input logic sd, input logic fd);
        int          nb;
        logic [5:0]  d;
        nb = nb_of(m);
        d  = 6'($urandom_range(0, (1 << nb) - 1));
        sb.push_back({d, c, sd, fd});
        for (int i = nb - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [7:0] ns);
        bus.frame_start = 1'b1;
        bus.mod_sel     = m;
        bus.n_sym       = ns;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        bus.mod_sel     = 2'b00;
        bus.n_sym       = 8'd0;
    endtask

    task automatic run_carriers(input logic [1:0] m, input int ns, input int s0, input int c0);
        for (int s = s0; s < ns; s++)
            for (int c = ((s == s0) ? c0 : 0); c < 48; c++)
                send_carrier(m, 6'(c), c == 47, (c == 47) && (s == ns - 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("busy_cleared", {31'd0, bus.busy}, 0);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int pl0;
        bus.frame_start = 1'b0;
        bus.mod_sel     = 2'b00;
        bus.n_sym       = 8'd0;
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {15'd0, bus.map_valid, bus.sym_done, bus.frame_done, bus.busy,
                              bus.map_data, bus.map_sel, bus.carr_idx}, 0);
        check("rst_bit_ready", {31'd0, bus.bit_ready}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 16QAM ordering and latency
        start_frame(2'b10, 8'd1);
        check("busy_after_start", {31'd0, bus.busy}, 1);
        sb.push_back({6'b001011, 6'd0, 1'b0, 1'b0});
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(posedge clk);
        #1;
        check("latency_16qam", {31'd0, bus.map_valid}, 1);
        run_carriers(2'b10, 1, 0, 1);
        wait_idle();

        // QPSK backpressure
        p0 = pulses;
        start_frame(2'b01, 8'd1);
        bus.out_ready = 1'b0;
        sb.push_back({6'b000010, 6'd0, 1'b0, 1'b0});
        send_bit(1'b1); send_bit(1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_no_strobe", {31'd0, bus.map_valid}, 0);
            check("bp_bit_ready", {31'd0, bus.bit_ready}, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        run_carriers(2'b01, 1, 0, 1);
        wait_idle();
        check("qpsk_pulses", pulses - p0, 48);

        // 64QAM, three symbols
        p0 = pulses;
        start_frame(2'b11, 8'd3);
        run_carriers(2'b11, 3, 0, 0);
        wait_idle();
        check("qam64_pulses", pulses - p0, 144);

        // Start rules: restart ignored mid-frame, n_sym=0 ignored
        p0  = pulses;
        pl0 = pilots;
        start_frame(2'b01, 8'd1);
        for (int c = 0; c < 3; c++) send_carrier(2'b01, 6'(c), 1'b0, 1'b0);
        start_frame(2'b11, 8'd5);
        check("map_sel_held", {30'd0, bus.map_sel}, 1);
        run_carriers(2'b01, 1, 0, 3);
        wait_idle();
        check("restart_pulses", pulses - p0, 48);
        start_frame(2'b10, 8'd0);
        @(negedge clk);
        check("nsym0_busy", {31'd0, bus.busy}, 0);
        check("nsym0_bit_ready", {31'd0, bus.bit_ready}, 0);
        @(posedge clk);
        #1;

        // BPSK frame; in the pilot build this also checks pilot placement
        pl0 = pilots;
        start_frame(2'b00, 8'd1);
        run_carriers(2'b00, 1, 0, 0);
        wait_idle();
`ifdef WIFI_TX_MAPPER_CTRL_PILOT_EN
        check("pilot_count", pilots - pl0, 4);
`endif

        // Reset in the middle of a 16QAM frame
        p0 = pulses;
        start_frame(2'b10, 8'd1);
        for (int c = 0; c < 10; c++) send_carrier(2'b10, 6'(c), 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_reset_pulses", pulses - p0, 10);
        #3;
        reset = 1'b0;
        sb.delete();
        sym_data = 0;
        pilot_k  = 0;
        #1;
        check("midrst_outputs", {15'd0, bus.map_valid, bus.sym_done, bus.frame_done, bus.busy,
                                 bus.map_data, bus.map_sel, bus.carr_idx}, 0);
        check("midrst_bit_ready", {31'd0, bus.bit_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        p0 = pulses;
        start_frame(2'b10, 8'd1);
        run_carriers(2'b10, 1, 0, 0);
        wait_idle();
        check("post_reset_pulses", pulses - p0, 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
